// File: rtl/ex.sv
// MIPS32 execute stage: logic/shift/arith results plus optional radix-2 divider (EX_DIV_EN).
// Latency: ALU ops combinational; DIV/DIVU 34 cycles (1 issue + 32 steps + 1 done), divide-by-zero 2.
// Backpressure: stallreq_o holds id_ex stable while a divide is issuing or iterating.
module ex (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic        annul_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o
);

    localparam logic [7:0] OP_AND  = 8'h24, OP_OR   = 8'h25, OP_XOR  = 8'h26, OP_NOR = 8'h27;
    localparam logic [7:0] OP_SLL  = 8'h7C, OP_SRL  = 8'h02, OP_SRA  = 8'h03;
    localparam logic [7:0] OP_ADDU = 8'h21, OP_SUBU = 8'h23, OP_SLT  = 8'h2A, OP_SLTU = 8'h2B;
    localparam logic [7:0] OP_DIV  = 8'h1A, OP_DIVU = 8'h1B;
    localparam logic [2:0] SEL_LOGIC = 3'b001, SEL_SHIFT = 3'b010, SEL_ARITH = 3'b100;

    logic [31:0] logic_res, shift_res, arith_res, alu_res;
    logic        is_div;
    logic        div_whilo, div_stall;
    logic [31:0] div_hi, div_lo;

    assign is_div = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);

    always_comb begin
        logic_res = '0;
        shift_res = '0;
        arith_res = '0;
        case (aluop_i)
            OP_AND:  logic_res = reg1_i & reg2_i;
            OP_OR:   logic_res = reg1_i | reg2_i;
            OP_XOR:  logic_res = reg1_i ^ reg2_i;
            OP_NOR:  logic_res = ~(reg1_i | reg2_i);
            OP_SLL:  shift_res = reg2_i << reg1_i[4:0];
            OP_SRL:  shift_res = reg2_i >> reg1_i[4:0];
            OP_SRA:  shift_res = $signed(reg2_i) >>> reg1_i[4:0];
            OP_ADDU: arith_res = reg1_i + reg2_i;
            OP_SUBU: arith_res = reg1_i - reg2_i;
            OP_SLT:  arith_res = {31'b0, $signed(reg1_i) < $signed(reg2_i)};
            OP_SLTU: arith_res = {31'b0, reg1_i < reg2_i};
            default: ;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (alusel_i)
            SEL_LOGIC: alu_res = logic_res;
            SEL_SHIFT: alu_res = shift_res;
            SEL_ARITH: alu_res = arith_res;
            default:   alu_res = '0;
        endcase
    end

`ifdef EX_DIV_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_t;

    div_state_t  state_q, state_d;
    logic [31:0] rem_q, quo_q, den_q;
    logic [4:0]  cnt_q;
    logic        neg_quo_q, neg_rem_q, dbz_q;
    logic        is_signed, start;
    logic [31:0] a_abs, b_abs;
    logic [32:0] partial, diff;

    assign is_signed = (aluop_i == OP_DIV);
    assign start     = is_div && !annul_i;
    assign a_abs     = (is_signed && reg1_i[31]) ? -reg1_i : reg1_i;
    assign b_abs     = (is_signed && reg2_i[31]) ? -reg2_i : reg2_i;
    assign partial   = {rem_q, quo_q[31]};
    assign diff      = partial - {1'b0, den_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = (reg2_i == '0) ? S_DONE : S_BUSY;
            S_BUSY: if (cnt_q == 5'd31) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (annul_i) state_d = S_IDLE;
    end

    // Restoring shift-subtract on magnitudes; signs are reapplied in DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q     <= '0;
            quo_q     <= '0;
            den_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
        end else if (state_q == S_IDLE && start) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            dbz_q     <= (reg2_i == '0);
            quo_q     <= (reg2_i == '0) ? reg1_i : a_abs;
            den_q     <= b_abs;
            neg_quo_q <= is_signed && (reg1_i[31] ^ reg2_i[31]);
            neg_rem_q <= is_signed && reg1_i[31];
        end else if (state_q == S_BUSY) begin
            cnt_q <= cnt_q + 5'd1;
            if (!diff[32]) begin
                rem_q <= diff[31:0];
                quo_q <= {quo_q[30:0], 1'b1};
            end else begin
                rem_q <= partial[31:0];
                quo_q <= {quo_q[30:0], 1'b0};
            end
        end
    end

    always_comb begin
        div_whilo = (state_q == S_DONE) && !annul_i;
        div_stall = (state_q == S_BUSY) || ((state_q == S_IDLE) && start);
        div_lo    = '0;
        div_hi    = '0;
        if (div_whilo) begin
            if (dbz_q) begin
                div_lo = 32'hFFFF_FFFF;
                div_hi = quo_q;
            end else begin
                div_lo = neg_quo_q ? -quo_q : quo_q;
                div_hi = neg_rem_q ? -rem_q : rem_q;
            end
        end
    end
`else
    logic unused_div_inputs;
    assign unused_div_inputs = clk ^ annul_i;
    assign div_whilo = 1'b0;
    assign div_stall = 1'b0;
    assign div_hi    = '0;
    assign div_lo    = '0;
`endif

    // Reset forces every output low combinationally, independent of clk.
    always_comb begin
        wd_o       = '0;
        wreg_o     = 1'b0;
        wdata_o    = '0;
        whilo_o    = 1'b0;
        hi_o       = '0;
        lo_o       = '0;
        stallreq_o = 1'b0;
        if (rst) begin
            wd_o       = wd_i;
            wreg_o     = wreg_i && !is_div;
            wdata_o    = alu_res;
            whilo_o    = div_whilo;
            hi_o       = div_hi;
            lo_o       = div_lo;
            stallreq_o = div_stall;
        end
    end

endmodule

// File: tb/tb_ex.sv
// Scoreboard bench for ex: ALU results checked same cycle, divide results checked on whilo_o.
module tb_ex;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i, annul_i;
    logic [4:0]  wd_o;
    logic        wreg_o, whilo_o, stallreq_o;
    logic [31:0] wdata_o, hi_o, lo_o;

    always #5 clk = ~clk;

    ex dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .annul_i(annul_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
    );

    typedef struct { logic [31:0] wdata; logic [4:0] wd; logic wreg; } alu_exp_t;
    typedef struct { logic [31:0] lo; logic [31:0] hi; int stalls; } div_exp_t;

    alu_exp_t alu_q[$];
    div_exp_t div_q[$];
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wd, input logic wreg);
        @(posedge clk);
        #1;
        aluop_i  = op;
        alusel_i = sel;
        reg1_i   = a;
        reg2_i   = b;
        wd_i     = wd;
        wreg_i   = wreg;
        annul_i  = 1'b0;
    endtask

    task automatic alu(input string tag, input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] wd,
                       input logic wreg, input logic [31:0] exp_w);
        alu_exp_t e;
        drive(op, sel, a, b, wd, wreg);
        alu_q.push_back('{exp_w, wd, wreg});
        @(negedge clk);
        e = alu_q.pop_front();
        chk(tag, wdata_o, e.wdata);
        chk({tag, "_wd"}, {27'b0, wd_o}, {27'b0, e.wd});
        chk({tag, "_wreg"}, {31'b0, wreg_o}, {31'b0, e.wreg});
        chk({tag, "_stall"}, {31'b0, stallreq_o}, 32'd0);
    endtask

    task automatic div_run(input string tag, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi, input int exp_stalls);
        div_exp_t e;
        int  stalls;
        bit  seen;
        stalls = 0;
        seen   = 1'b0;
        drive(op, 3'b000, a, b, 5'd9, 1'b1);
`ifdef EX_DIV_EN
        div_q.push_back('{exp_lo, exp_hi, exp_stalls});
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (whilo_o) begin
                seen = 1'b1;
                e = div_q.pop_front();
                chk({tag, "_lo"}, lo_o, e.lo);
                chk({tag, "_hi"}, hi_o, e.hi);
                chk({tag, "_stalls"}, stalls, e.stalls);
                chk({tag, "_done_stall"}, {31'b0, stallreq_o}, 32'd0);
                chk({tag, "_wreg"}, {31'b0, wreg_o}, 32'd0);
            end else if (stallreq_o) begin
                stalls++;
            end
        end
        if (!seen) begin
            void'(div_q.pop_front());
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end
`else
        div_q.push_back('{32'd0, 32'd0, 0});
        @(negedge clk);
        e = div_q.pop_front();
        chk({tag, "_lo"}, lo_o, e.lo);
        chk({tag, "_hi"}, hi_o, e.hi);
        chk({tag, "_stall"}, {31'b0, stallreq_o}, e.stalls);
        chk({tag, "_whilo"}, {31'b0, whilo_o}, 32'd0);
        chk({tag, "_wreg"}, {31'b0, wreg_o}, 32'd0);
`endif
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wd"}, {27'b0, wd_o}, 32'd0);
        chk({tag, "_wreg"}, {31'b0, wreg_o}, 32'd0);
        chk({tag, "_wdata"}, wdata_o, 32'd0);
        chk({tag, "_whilo"}, {31'b0, whilo_o}, 32'd0);
        chk({tag, "_hi"}, hi_o, 32'd0);
        chk({tag, "_lo"}, lo_o, 32'd0);
        chk({tag, "_stall"}, {31'b0, stallreq_o}, 32'd0);
    endtask

    initial begin
        int whilo_seen;
        rst      = 1'b0;
        aluop_i  = 8'h25;
        alusel_i = 3'b001;
        reg1_i   = 32'h1234_5678;
        reg2_i   = 32'h0F0F_0F0F;
        wd_i     = 5'd3;
        wreg_i   = 1'b1;
        annul_i  = 1'b0;
        #7;
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        aluop_i = 8'h00;
        alusel_i = 3'b000;
        rst = 1'b1;

        alu("or",    8'h25, 3'b001, 32'h0000_F0F0, 32'h0000_0F0F, 5'd5, 1'b1, 32'h0000_FFFF);
        alu("sra",   8'h03, 3'b010, 32'd4,         32'h8000_0000, 5'd6, 1'b1, 32'hF800_0000);
        alu("slt",   8'h2A, 3'b100, 32'hFFFF_FFFF, 32'd1,         5'd7, 1'b1, 32'd1);
        alu("sltu",  8'h2B, 3'b100, 32'hFFFF_FFFF, 32'd1,         5'd8, 1'b1, 32'd0);
        alu("addu",  8'h21, 3'b100, 32'hFFFF_FFFF, 32'd2,         5'd9, 1'b1, 32'd1);
        alu("subu",  8'h23, 3'b100, 32'd0,         32'd1,         5'd10, 1'b0, 32'hFFFF_FFFF);
        alu("sll",   8'h7C, 3'b010, 32'd8,         32'd1,         5'd11, 1'b1, 32'h0000_0100);
        alu("srl",   8'h02, 3'b010, 32'd4,         32'h8000_0000, 5'd12, 1'b1, 32'h0800_0000);
        alu("nor",   8'h27, 3'b001, 32'd0,         32'h0000_00FF, 5'd13, 1'b1, 32'hFFFF_FF00);
        alu("xor",   8'h26, 3'b001, 32'hAAAA_5555, 32'hFFFF_0000, 5'd14, 1'b1, 32'h5555_5555);
        alu("badsel", 8'h24, 3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 1'b1, 32'd0);

        div_run("div_m7_2",   8'h1A, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        div_run("divu_7_2",   8'h1B, 32'd7, 32'd2, 32'd3, 32'd1, 33);
        div_run("div_7_m2",   8'h1A, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
        div_run("div_ovf",    8'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
        div_run("divu_5_0",   8'h1B, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1);

        // Flush a divide partway through BUSY.
        drive(8'h1B, 3'b000, 32'd1000, 32'd3, 5'd9, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        annul_i = 1'b1;
        @(negedge clk);
`ifdef EX_DIV_EN
        chk("annul_busy_stall", {31'b0, stallreq_o}, 32'd1);
`else
        chk("annul_busy_stall", {31'b0, stallreq_o}, 32'd0);
`endif
        chk("annul_cycle_whilo", {31'b0, whilo_o}, 32'd0);
        drive(8'h00, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
        @(negedge clk);
        chk("annul_next_stall", {31'b0, stallreq_o}, 32'd0);
        whilo_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (whilo_o) whilo_seen++;
        end
        chk("annul_whilo_count", whilo_seen, 32'd0);
        div_run("divu_9_3",   8'h1B, 32'd9, 32'd3, 32'd3, 32'd0, 33);

        // Asynchronous reset mid-divide.
        drive(8'h1B, 3'b000, 32'd1000, 32'd3, 5'd7, 1'b1);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk_all_zero("arst");
        aluop_i = 8'h00;
        wreg_i  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        div_run("divu_100_7", 8'h1B, 32'd100, 32'd7, 32'd14, 32'd2, 33);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ex.md
# ex

Execute stage of the 5-stage MIPS32 pipeline. Consumes the decoded operation produced by `id`, registered through `id_ex`: ALU op, ALU select, two 32-bit operands, destination register and write enable. Produces the write-back result for `ex_mem`. Contains a 32-iteration radix-2 signed/unsigned divider that stalls the front of the pipeline while busy.

## Interface
Parameters:
- none; widths come from `define.v` (`RegBus`=32, `RegAddrBus`=5, `AluOpBus`=8, `AluSelBus`=3).

Ports:
- `clk`  in  1  pipeline clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `aluop_i`  in  8  operation code from `id_ex`.
- `alusel_i`  in  3  result class from `id_ex`.
- `reg1_i`  in  32  operand 1 (shift amount in [4:0] for shifts; dividend).
- `reg2_i`  in  32  operand 2 (shifted value; divisor).
- `wd_i`  in  5  destination register address.
- `wreg_i`  in  1  destination write enable.
- `annul_i`  in  1  pipeline flush; aborts an in-flight divide.
- `wd_o`  out  5  destination address to `ex_mem`.
- `wreg_o`  out  1  register write enable to `ex_mem`.
- `wdata_o`  out  32  GPR write data.
- `whilo_o`  out  1  HI/LO write enable.
- `hi_o`  out  32  HI value (remainder).
- `lo_o`  out  32  LO value (quotient).
- `stallreq_o`  out  1  stall request to `ctrl`.

## Operation
- Op codes: NOP 8'h00, AND 8'h24, OR 8'h25, XOR 8'h26, NOR 8'h27, SLL 8'h7C, SRL 8'h02, SRA 8'h03, ADDU 8'h21, SUBU 8'h23, SLT 8'h2A, SLTU 8'h2B, DIV 8'h1A, DIVU 8'h1B.
- Select codes: NOP 3'b000, LOGIC 3'b001, SHIFT 3'b010, ARITH 3'b100. `wdata_o` is muxed by `alusel_i`; unknown select gives 0.
- Logic, shift and arithmetic ops are combinational. Shifts use `reg1_i[4:0]` as the amount. ADDU/SUBU wrap modulo 2^32 with no trap. SLT is signed compare, SLTU unsigned; result is 0 or 1.
- `wd_o`/`wreg_o` pass `wd_i`/`wreg_i` through, except `wreg_o`=0 for DIV/DIVU.
- Divider FSM states:
  - IDLE → BUSY when DIV/DIVU is present, `annul_i`=0 and the divisor ≠ 0. Captures |dividend|, |divisor| (DIV) or raw values (DIVU), plus sign flags. Clears the iteration counter.
  - IDLE → DONE when the divisor is 0.
  - BUSY runs one shift-subtract step per cycle. After 32 steps → DONE.
  - DONE → IDLE unconditionally.
  - `annul_i`=1 in any state → IDLE next edge. No HI/LO write occurs.
- Signed fix-up in DONE: quotient negated if the operand signs differ; remainder takes the dividend's sign. 0x80000000 / -1 gives LO=0x80000000, HI=0.
- Divide by zero: LO=32'hFFFFFFFF, HI=dividend.
- `whilo_o`=1 only in DONE with `annul_i`=0; `hi_o`/`lo_o` are valid then and 0 otherwise.
- `stallreq_o`=1 combinationally in IDLE while a DIV/DIVU is present and not annulled, and for all of BUSY. It is 0 in DONE.
- `id_ex` holds its inputs stable while stalled.
- While `rst`=0, all outputs are 0 and the FSM is in IDLE, counter 0.

## Timing
- Non-divide ops: zero-cycle latency; outputs are valid the same cycle as inputs.
- DIV/DIVU with nonzero divisor: issue cycle (IDLE), 32 BUSY cycles, then 1 DONE cycle. That is 34 cycles in EX and 33 stall cycles.
- Divide by zero: issue cycle, then DONE; 1 stall cycle.
- Back-to-back divides: the second is seen in IDLE the cycle after DONE.
- Reset assertion mid-divide: immediate return to IDLE and all outputs 0, independent of `clk`.

## Configuration
- `EX_DIV_EN` defined: divider FSM and HI/LO outputs behave as above.
- `EX_DIV_EN` undefined: no divider state is synthesised. DIV/DIVU act as NOP: `wreg_o`=0, `whilo_o`=0, `hi_o`=`lo_o`=0, `stallreq_o` tied 0.

## Test plan
- OR 0x0000F0F0 | 0x00000F0F, wd=5, wreg=1 → same cycle `wdata_o`=0x0000FFFF, `wd_o`=5, `wreg_o`=1, `stallreq_o`=0.
- SRA amount 4, value 0x80000000 → 0xF8000000. SLT -1 vs 1 → 1. SLTU 0xFFFFFFFF vs 1 → 0.
- DIV -7 / 2 → `stallreq_o` high for 33 cycles; on cycle 34 `whilo_o`=1, LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 → LO=3, HI=1.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. DIVU 5/0 → stall 1 cycle, then LO=0xFFFFFFFF, HI=5.
- `annul_i` pulsed at BUSY cycle 10 → next cycle `stallreq_o`=0 and `whilo_o` never asserted. A subsequent DIVU 9/3 completes normally with LO=3, HI=0.
- `rst` dropped low mid-BUSY → all outputs 0 asynchronously. After release, a new DIVU 100/7 gives LO=14, HI=2 after 34 cycles.
